// File: rtl/relu_guard_compact_wb_pkg.sv
// Shared types and defaults for the ReLU/guard compacting write-back stage.
package diff_core_pkg;

  localparam int unsigned DEF_PSUM_WIDTH = 16;
  localparam int unsigned DEF_LANES      = 6;

  typedef enum logic [1:0] {
    SPARSE8 = 2'd0,
    DENSE4  = 2'd1,
    DENSE8  = 2'd2
  } wb_mode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } wb_state_t;

  // The reserved encoding 3 behaves as DENSE8.
  function automatic wb_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return SPARSE8;
      2'd1:    return DENSE4;
      default: return DENSE8;
    endcase
  endfunction

endpackage

// File: rtl/relu_guard_compact_wb_relu_sat_lane.sv
// One PSUM lane: ReLU, arithmetic right shift, clamp to 8 or 4 bits, nonzero flag.
module relu_sat_lane
  import diff_core_pkg::*;
#(
  parameter int unsigned PSUM_WIDTH = DEF_PSUM_WIDTH
) (
  input  logic [PSUM_WIDTH-1:0] psum,
  input  logic [3:0]            shift,
  input  wb_mode_t              mode,
  output logic [7:0]            value,
  output logic                  nonzero
);

  logic [PSUM_WIDTH-1:0] shifted;

  always_comb begin
    shifted = '0;
    if (!psum[PSUM_WIDTH-1]) shifted = psum >> shift;
    if (mode == DENSE4)
      value = (shifted > PSUM_WIDTH'(15)) ? 8'd15 : {4'b0000, shifted[3:0]};
    else
      value = (shifted > PSUM_WIDTH'(255)) ? 8'd255 : shifted[7:0];
    nonzero = |value;
  end

endmodule

// File: rtl/relu_guard_compact_wb.sv
// Write-back stage: fetches PSUM words, applies ReLU/shift/saturation per lane and
// emits nonzero bytes plus a guard bitmap (SPARSE8) or every lane/pair (dense modes).
module relu_guard_compact_wb
  import diff_core_pkg::*;
#(
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned PSUM_WIDTH = DEF_PSUM_WIDTH,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ctrl_valid,
  output logic                        ctrl_ready,
  output logic                        ctrl_finish,
  input  logic [15:0]                 pace_i,
  input  logic [1:0]                  mode_i,
  input  logic [3:0]                  shift_i,
  input  logic [LANES*PSUM_WIDTH-1:0] data_i,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           addr_o,
  output logic [7:0]                  data_o,
  output logic                        data_o_valid,
  input  logic                        fm_buf_ready,
  output logic [LANES-1:0]            guard_o,
  output logic                        guard_o_valid,
  input  logic                        guard_buf_ready
);

  wb_state_t        state, state_nxt;
  wb_mode_t         mode_q;
  logic [15:0]      pace_q, word_cnt;
  logic [3:0]       shift_q;
  logic [7:0]       lane_val [LANES];
  logic [LANES-1:0] lane_nz;
  logic [7:0]       val_q [LANES];
  logic [LANES-1:0] pending, guard_q, load_mask, low_oh;
  logic             guard_pending;
  logic [7:0]       pick_byte;
  logic             accept, word_done, fm_fire, guard_fire;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    relu_sat_lane #(.PSUM_WIDTH(PSUM_WIDTH)) u_lane (
      .psum    (data_i[k*PSUM_WIDTH +: PSUM_WIDTH]),
      .shift   (shift_q),
      .mode    (mode_q),
      .value   (lane_val[k]),
      .nonzero (lane_nz[k])
    );
  end

  assign accept     = (state == IDLE) && ctrl_valid;
  assign word_done  = (state == EMIT) && (pending == '0) && !guard_pending;
  assign fm_fire    = data_o_valid && fm_buf_ready;
  assign guard_fire = guard_o_valid && guard_buf_ready;
  assign low_oh     = pending & (-pending);

  always_comb begin
    load_mask = '0;
    case (mode_q)
      SPARSE8: load_mask = lane_nz;
      DENSE4:  for (int unsigned i = 0; i < LANES / 2; i++) load_mask[i] = 1'b1;
      default: load_mask = '1;
    endcase
  end

  // Scan from the top so the lowest pending index is the one that sticks.
  always_comb begin
    pick_byte = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (pending[LANES-1-i]) begin
        if (mode_q == DENSE4) begin
          if (LANES-1-i < LANES / 2)
            pick_byte = {val_q[2*(LANES-1-i)+1][3:0], val_q[2*(LANES-1-i)][3:0]};
        end else begin
          pick_byte = val_q[LANES-1-i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_valid) state_nxt = (pace_i == 16'd0) ? DONE : FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = EMIT;
      EMIT:    if (word_done) state_nxt = ((word_cnt + 16'd1) == pace_q) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ctrl_ready    = (state == IDLE);
    ctrl_finish   = (state == DONE);
    rd_en         = (state == FETCH);
    data_o_valid  = (state == EMIT) && (pending != '0);
    guard_o_valid = (state == EMIT) && guard_pending;
    data_o        = data_o_valid ? pick_byte : '0;
    guard_o       = guard_o_valid ? guard_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pace_q        <= '0;
      mode_q        <= SPARSE8;
      shift_q       <= '0;
      word_cnt      <= '0;
      addr_o        <= '0;
      val_q         <= '{default: '0};
      pending       <= '0;
      guard_q       <= '0;
      guard_pending <= 1'b0;
    end else begin
      if (accept) begin
        pace_q   <= pace_i;
        mode_q   <= decode_mode(mode_i);
        shift_q  <= shift_i;
        word_cnt <= '0;
        addr_o   <= '0;
      end
      if (state == LOAD) begin
        val_q         <= lane_val;
        pending       <= load_mask;
        guard_q       <= (mode_q == SPARSE8) ? lane_nz : '0;
        guard_pending <= (mode_q == SPARSE8);
      end
      if (fm_fire)    pending       <= pending & ~low_oh;
      if (guard_fire) guard_pending <= 1'b0;
      if (word_done) begin
        word_cnt <= word_cnt + 16'd1;
        addr_o   <= addr_o + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_relu_guard_compact_wb.sv
// Directed bench for relu_guard_compact_wb with a synchronous-read PSUM memory model.
module tb_relu_guard_compact_wb;

  localparam int unsigned LANES = 6;
  localparam int unsigned PW    = 16;
  localparam int unsigned AW    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ctrl_valid = 1'b0;
  logic              ctrl_ready, ctrl_finish;
  logic [15:0]       pace_i = '0;
  logic [1:0]        mode_i = '0;
  logic [3:0]        shift_i = '0;
  logic [LANES*PW-1:0] data_i = '0;
  logic              rd_en;
  logic [AW-1:0]     addr_o;
  logic [7:0]        data_o;
  logic              data_o_valid;
  logic              fm_buf_ready;
  logic [LANES-1:0]  guard_o;
  logic              guard_o_valid;
  logic              guard_buf_ready = 1'b1;

  logic              fm_toggle = 1'b0;
  logic              fm_level = 1'b1;
  int                cyc = 0;

  logic [LANES*PW-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  int fm_q[$], fm_cyc[$], rd_q[$], rd_cyc[$], g_q[$], g_cyc[$];
  int gv_cycles = 0, fin_cnt = 0, idle_viol = 0, stall_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  assign fm_buf_ready = fm_toggle ? cyc[0] : fm_level;

  relu_guard_compact_wb #(.LANES(LANES), .PSUM_WIDTH(PW), .ADDR_W(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctrl_valid      (ctrl_valid),
    .ctrl_ready      (ctrl_ready),
    .ctrl_finish     (ctrl_finish),
    .pace_i          (pace_i),
    .mode_i          (mode_i),
    .shift_i         (shift_i),
    .data_i          (data_i),
    .rd_en           (rd_en),
    .addr_o          (addr_o),
    .data_o          (data_o),
    .data_o_valid    (data_o_valid),
    .fm_buf_ready    (fm_buf_ready),
    .guard_o         (guard_o),
    .guard_o_valid   (guard_o_valid),
    .guard_buf_ready (guard_buf_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rd_en) data_i <= mem[addr_o];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin rd_q.push_back(int'(addr_o)); rd_cyc.push_back(cyc); end
      if (data_o_valid && fm_buf_ready) begin fm_q.push_back(int'(data_o)); fm_cyc.push_back(cyc); end
      if (guard_o_valid) gv_cycles <= gv_cycles + 1;
      if (guard_o_valid && guard_buf_ready) begin g_q.push_back(int'(guard_o)); g_cyc.push_back(cyc); end
      if (ctrl_finish) fin_cnt <= fin_cnt + 1;
      if ((!data_o_valid && data_o != '0) || (!guard_o_valid && guard_o != '0)) idle_viol <= idle_viol + 1;
      if (stall_prev) begin
        check("stall_valid_held", 32'(data_o_valid), 32'd1);
        check("stall_data_held", 32'(data_o), 32'(stall_data));
      end
      if (data_o_valid && !fm_buf_ready) stall_cnt <= stall_cnt + 1;
      stall_prev <= data_o_valid && !fm_buf_ready;
      stall_data <= data_o;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  function automatic logic [LANES*PW-1:0] pack(input int l0, l1, l2, l3, l4, l5);
    logic [LANES*PW-1:0] w;
    int v[6];
    v = '{l0, l1, l2, l3, l4, l5};
    w = '0;
    for (int i = 0; i < 6; i++) w[i*PW +: PW] = 16'(v[i]);
    return w;
  endfunction

  task automatic start_job(input int pace, input int mode, input int shift, output int acc);
    @(posedge clk); #1;
    ctrl_valid = 1'b1;
    pace_i     = 16'(pace);
    mode_i     = 2'(mode);
    shift_i    = 4'(shift);
    @(posedge clk); #1;
    ctrl_valid = 1'b0;
    acc        = cyc;
  endtask

  task automatic wait_finish(input string tag, input int budget, output int busy_ready);
    int n;
    n = 0;
    busy_ready = 0;
    do begin
      @(negedge clk);
      n++;
      if (ctrl_ready) busy_ready++;
    end while (!ctrl_finish && n < budget);
    check({tag, "_finish_seen"}, 32'(ctrl_finish), 32'd1);
    check({tag, "_ready_low_while_busy"}, 32'(busy_ready), 32'd0);
    @(negedge clk);
    check({tag, "_ready_after_finish"}, 32'(ctrl_ready), 32'd1);
  endtask

  int acc, br, fb, rb, gb, gvb, finb, sb, n;
  int exp_d4[6];
  int exp_d8[18];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl_ready", 32'(ctrl_ready), 32'd1);
    check("rst_ctrl_finish", 32'(ctrl_finish), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_data_valid", 32'(data_o_valid), 32'd0);
    check("rst_guard_valid", 32'(guard_o_valid), 32'd0);
    #1 rst_n = 1'b1;

    // SPARSE8, single word
    mem[0] = pack(-5, 0, 300, 7, 0, 1);
    fb = fm_q.size(); rb = rd_q.size(); gb = g_q.size(); finb = fin_cnt;
    start_job(1, 0, 0, acc);
    wait_finish("sp1", 60, br);
    check("sp1_fm_count", 32'(fm_q.size() - fb), 32'd3);
    check("sp1_byte0", 32'(fm_q[fb]), 32'd255);
    check("sp1_byte1", 32'(fm_q[fb+1]), 32'd7);
    check("sp1_byte2", 32'(fm_q[fb+2]), 32'd1);
    check("sp1_first_fm_cycle", 32'(fm_cyc[fb]), 32'(acc + 2));
    check("sp1_rd_count", 32'(rd_q.size() - rb), 32'd1);
    check("sp1_rd_addr", 32'(rd_q[rb]), 32'd0);
    check("sp1_rd_cycle", 32'(rd_cyc[rb]), 32'(acc));
    check("sp1_guard_count", 32'(g_q.size() - gb), 32'd1);
    check("sp1_guard", 32'(g_q[gb]), 32'h2C);
    check("sp1_finish_pulses", 32'(fin_cnt - finb), 32'd1);

    // DENSE4, two words
    mem[0] = pack(20, 3, 100, -1, 8, 64);
    mem[1] = pack(4, 8, 60, 61, -100, 7);
    exp_d4 = '{8'h05, 8'h0F, 8'hF2, 8'h21, 8'hFF, 8'h10};
    fb = fm_q.size(); rb = rd_q.size(); gvb = gv_cycles;
    start_job(2, 1, 2, acc);
    wait_finish("d4", 80, br);
    check("d4_fm_count", 32'(fm_q.size() - fb), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("d4_byte%0d", i), 32'(fm_q[fb+i]), 32'(exp_d4[i]));
    check("d4_rd_count", 32'(rd_q.size() - rb), 32'd2);
    check("d4_rd_addr0", 32'(rd_q[rb]), 32'd0);
    check("d4_rd_addr1", 32'(rd_q[rb+1]), 32'd1);
    check("d4_no_guard", 32'(gv_cycles - gvb), 32'd0);

    // DENSE8, three words, FM ready toggling
    mem[0] = pack(1, 2, 3, 4, 5, 6);
    mem[1] = pack(255, 256, -1, 0, 100, 1000);
    mem[2] = pack(10, 20, 30, 40, 50, 60);
    exp_d8 = '{1, 2, 3, 4, 5, 6, 255, 255, 0, 0, 100, 255, 10, 20, 30, 40, 50, 60};
    fb = fm_q.size(); sb = stall_cnt;
    @(posedge clk); #1 fm_toggle = 1'b1;
    start_job(3, 2, 0, acc);
    wait_finish("d8", 300, br);
    #1 fm_toggle = 1'b0;
    check("d8_fm_count", 32'(fm_q.size() - fb), 32'd18);
    for (int i = 0; i < 18; i++) check($sformatf("d8_byte%0d", i), 32'(fm_q[fb+i]), 32'(exp_d8[i]));
    check("d8_stalls_seen", 32'(stall_cnt - sb > 0), 32'd1);

    // SPARSE8 all-zero words, guard buffer stalled 4 cycles on the first
    mem[0] = '0;
    mem[1] = '0;
    fb = fm_q.size(); rb = rd_q.size(); gb = g_q.size(); gvb = gv_cycles;
    @(posedge clk); #1 guard_buf_ready = 1'b0;
    start_job(2, 0, 0, acc);
    n = 0;
    do begin @(negedge clk); n++; end while (!guard_o_valid && n < 20);
    check("z_guard_valid_seen", 32'(guard_o_valid), 32'd1);
    repeat (4) @(posedge clk);
    #1 guard_buf_ready = 1'b1;
    wait_finish("z", 60, br);
    check("z_fm_count", 32'(fm_q.size() - fb), 32'd0);
    check("z_guard_count", 32'(g_q.size() - gb), 32'd2);
    check("z_guard0", 32'(g_q[gb]), 32'd0);
    check("z_guard_hs_cycle", 32'(g_cyc[gb]), 32'(acc + 6));
    check("z_guard_valid_cycles", 32'(gv_cycles - gvb), 32'd6);
    check("z_rd_count", 32'(rd_q.size() - rb), 32'd2);
    check("z_word1_after_guard", 32'(rd_cyc[rb+1]), 32'(g_cyc[gb] + 2));

    // pace 0 with ctrl_valid held high while busy
    rb = rd_q.size(); finb = fin_cnt;
    @(posedge clk); #1;
    ctrl_valid = 1'b1; pace_i = '0; mode_i = 2'd2; shift_i = '0;
    @(posedge clk);
    @(negedge clk);
    check("p0_finish", 32'(ctrl_finish), 32'd1);
    check("p0_ready_low", 32'(ctrl_ready), 32'd0);
    @(negedge clk);
    check("p0_ready_back", 32'(ctrl_ready), 32'd1);
    check("p0_finish_one_cycle", 32'(ctrl_finish), 32'd0);
    #1 ctrl_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("p0_single_job", 32'(fin_cnt - finb), 32'd1);
    check("p0_no_reads", 32'(rd_q.size() - rb), 32'd0);

    // reset during EMIT of word 1 of 3
    mem[0] = pack(1, 1, 1, 1, 1, 1);
    mem[1] = pack(2, 2, 2, 2, 2, 2);
    mem[2] = pack(3, 3, 3, 3, 3, 3);
    rb = rd_q.size(); finb = fin_cnt;
    start_job(3, 2, 0, acc);
    n = 0;
    do begin @(negedge clk); n++; end while (!(data_o_valid && rd_q.size() - rb == 2) && n < 100);
    check("rs_reached_word1", 32'(data_o_valid && (rd_q.size() - rb == 2)), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rs_ready", 32'(ctrl_ready), 32'd1);
    check("rs_data_valid", 32'(data_o_valid), 32'd0);
    check("rs_data", 32'(data_o), 32'd0);
    check("rs_addr", 32'(addr_o), 32'd0);
    check("rs_rd_en", 32'(rd_en), 32'd0);
    check("rs_finish", 32'(ctrl_finish), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rs_no_finish", 32'(fin_cnt - finb), 32'd0);
    rb = rd_q.size(); fb = fm_q.size();
    start_job(1, 2, 0, acc);
    wait_finish("rs2", 60, br);
    check("rs2_rd_addr", 32'(rd_q[rb]), 32'd0);
    check("rs2_fm_count", 32'(fm_q.size() - fb), 32'd6);
    check("rs2_byte0", 32'(fm_q[fb]), 32'd1);

    check("idle_outputs_zero", 32'(idle_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/relu_guard_compact_wb.md
Name: relu_guard_compact_wb

Overview:
Parametrised successor of the ReLU/guard write-back stage. It reads LANES-wide partial-sum words from the PSUM buffer and applies ReLU, arithmetic right-shift and saturation to each lane. In sparse mode it writes only the nonzero lanes to the feature-map buffer and one guard (nonzero bitmap) per word to the guard buffer; in dense modes it writes every lane, as 8-bit bytes or as packed 4-bit pairs. It sits between the accumulator PSUM buffer and the FM/guard buffers. It is controlled by a valid/ready start handshake and a one-cycle finish pulse.

Parameters:
LANES, 6, number of PSUM lanes per buffer word; must be even for the 4-bit mode.
PSUM_WIDTH, 16, width of each signed partial-sum lane.
ADDR_W, 8, PSUM buffer address width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ctrl_valid  in  1  start request
ctrl_ready  out  1  block idle and able to accept a job
ctrl_finish  out  1  one-cycle pulse when the job completes
pace_i  in  16  number of PSUM words in the job
mode_i  in  2  0 = SPARSE8, 1 = DENSE4, 2 = DENSE8; 3 is reserved and treated as DENSE8
shift_i  in  4  right shift applied after ReLU
data_i  in  LANES*PSUM_WIDTH  PSUM read data; lane k occupies bits [k*PSUM_WIDTH +: PSUM_WIDTH]
rd_en  out  1  PSUM read strobe
addr_o  out  ADDR_W  PSUM read address
data_o  out  8  FM write data
data_o_valid  out  1  FM write valid
fm_buf_ready  in  1  FM buffer ready
guard_o  out  LANES  nonzero bitmap; bit k corresponds to lane k
guard_o_valid  out  1  guard write valid
guard_buf_ready  in  1  guard buffer ready

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset forces IDLE, ctrl_ready = 1, and every other output and internal register to 0. Reset asserted mid-job aborts the job: no finish pulse, no further writes.
- Accept: a job is accepted when ctrl_valid && ctrl_ready. On acceptance the block latches pace_i, mode_i and shift_i, clears word_cnt and addr_o, and drops ctrl_ready. ctrl_valid is ignored while busy. ctrl_ready returns to 1 in the cycle after ctrl_finish.
- States and transitions:
  - IDLE -> FETCH on accept.
  - IDLE -> DONE on accept when pace_i = 0; no reads are issued.
  - FETCH: rd_en = 1 for exactly one cycle with the current addr_o; -> LOAD.
  - LOAD: data_i, valid exactly one cycle after rd_en, is processed per lane and registered. The pending mask is loaded. In SPARSE8, guard_pending is set. -> EMIT.
  - EMIT -> FETCH, or -> DONE, once the pending mask is empty and guard_pending = 0. On that transition word_cnt and addr_o increment. The target is DONE if word_cnt+1 == pace, otherwise FETCH.
  - DONE: ctrl_finish = 1 for one cycle; -> IDLE.
- Timing: with both buffers always ready, accept is cycle 0, rd_en is cycle 1, and the first data_o_valid is cycle 3.
- Lane processing:
  - ReLU: v = 0 if the lane is negative, else v = lane >> shift.
  - Saturation: v is clamped to 255 (SPARSE8, DENSE8) or to 15 (DENSE4).
  - Guard bit: guard bit k = (saturated v_k != 0). It is evaluated after the shift, so a zero byte is never written in SPARSE8.
- Emission order is always the lowest pending index first.
  - SPARSE8: pending mask = guard. data_o = the byte of the lowest set bit.
  - DENSE8: all LANES bits are pending. data_o = the byte of the lowest pending lane.
  - DENSE4: LANES/2 pair bits are pending. Pair p gives data_o = {v[2p+1][3:0], v[2p][3:0]}.
- FM handshake: data_o_valid = 1 while EMIT and the mask is nonzero. The pending bit clears only on data_o_valid && fm_buf_ready. data_o stays stable while valid && !ready. Each lane, or pair, is written exactly once.
- Guard handshake (SPARSE8 only): guard_o_valid = guard_pending during EMIT, concurrent with the FM writes. guard_pending clears on guard_o_valid && guard_buf_ready. An all-zero word produces guard 0 and no FM writes. Guard never asserts in the dense modes.
- Backpressure: the two buffers stall independently; a stall on one never blocks the other.
- Width rules: word_cnt is 16-bit. addr_o wraps modulo 2^ADDR_W; pace > 2^ADDR_W is legal and wraps.
- Idle outputs: data_o and guard_o are 0 whenever their valid is low.

Decomposition:
- Package diff_core_pkg holds:
  - wb_mode_t (SPARSE8, DENSE4, DENSE8);
  - wb_state_t (IDLE, FETCH, LOAD, EMIT, DONE);
  - the default PSUM_WIDTH and LANES constants.
- Sub-module relu_sat_lane, instantiated LANES times. It is combinational. Inputs: psum, shift, mode. Outputs: the saturated 8-bit value and the nonzero flag.
- The top level holds the FSM, the counters, the pending mask, the priority picker and the handshakes.

Test Plan:
- SPARSE8, pace = 1, shift = 0, lanes {0:-5, 1:0, 2:300, 3:7, 4:0, 5:1}, both buffers ready -> guard_o = 6'b101100; data_o sequence 255, 7, 1; one ctrl_finish pulse; rd_en seen once at addr 0.
- DENSE4, pace = 2, shift = 2, word0 lanes {20, 3, 100, -1, 8, 64} -> data_o 0x05, 0x0F, 0xF2. addr_o steps 0 then 1. No guard_o_valid.
- DENSE8, pace = 3, fm_buf_ready toggling 1010 -> 18 bytes in lane order; data_o held stable during every stall; ctrl_ready = 1 only after ctrl_finish.
- SPARSE8 all-zero word plus guard_buf_ready low for 4 cycles -> no FM writes; guard 0 held valid for 5 cycles; word advances only after the guard handshake.
- pace_i = 0 -> no rd_en; ctrl_finish is asserted 1 cycle after the accept cycle; ctrl_ready returns the cycle after. ctrl_valid held high while busy -> exactly one job is accepted.
- rst_n asserted during EMIT of word 1 of 3 -> all outputs 0 and ctrl_ready = 1 immediately, no finish pulse. A new job afterwards restarts at addr 0.
